// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch initiator with a PC-tagged prefetch FIFO and
//               flush-on-redirect. Optional IFETCH_PERF_EN adds a pop counter.
// Revision    : 1.0
// ============================================================================
module instr_fetch #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0004,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        err_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ERR   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       pc_mem_q   [FIFO_DEPTH];
  logic [31:0]       pc_mem_d   [FIFO_DEPTH];
  logic [31:0]       data_mem_q [FIFO_DEPTH];
  logic [31:0]       data_mem_d [FIFO_DEPTH];

  logic full;
  logic empty;
  logic misaligned;
  logic push;
  logic pop;

  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign misaligned = (redirect_pc_i[1:0] != 2'b00);

  // A pending redirect masks both handshakes so nothing stale crosses the flush.
  assign req_o         = (state_q == S_FETCH) & ~full & ~redirect_i;
  assign instr_valid_o = ~empty & ~redirect_i;
  assign push          = req_o;
  assign pop           = instr_valid_o & instr_ready_i;

  assign we_o       = 1'b0;
  assign wdata_o    = 32'h0;
  assign addr_o     = {2'b00, pc_q[31:2]};
  assign instr_o    = data_mem_q[rd_ptr_q];
  assign instr_pc_o = pc_mem_q[rd_ptr_q];
  assign err_o      = (state_q == S_ERR);

  always_comb begin
    state_d = state_q;
    if (redirect_i && misaligned) begin
      state_d = S_ERR;
    end else if (redirect_i && state_q == S_ERR) begin
      state_d = fetch_en_i ? S_FETCH : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (fetch_en_i)  state_d = S_FETCH;
        S_FETCH: if (!fetch_en_i) state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    pc_d       = pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    data_mem_d = data_mem_q;
    if (redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      if (!misaligned) pc_d = redirect_pc_i;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = pc_q;
        data_mem_d[wr_ptr_q] = rdata_i;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        pc_d                 = pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= BOOT_ADDR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pc_mem_q   <= '{default: '0};
      data_mem_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pc_mem_q   <= pc_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

`ifdef IFETCH_PERF_EN
  // Counts delivered instructions; survives redirects, cleared only by reset.
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (pop) fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) fetch_cnt_q <= '0;
    else       fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch initiator for the core. Drives the request side of the instruction SRAM port: it issues word reads, captures the returned instruction words into a small prefetch FIFO tagged with their PC, and hands them to decode over a valid/ready handshake. Branch and jump redirects from execute flush the FIFO and restart fetch at the new target.

## Interface
Parameters:
- `BOOT_ADDR`, default 32'h0000_0004: byte PC loaded on reset.
- `FIFO_DEPTH`, default 4: prefetch entries; power of two, at least 2.

Ports:
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous and active-high.
- `fetch_en_i` input 1: enables fetching.
- `redirect_i` input 1: flush and redirect request.
- `redirect_pc_i` input 32: byte target PC for the redirect.
- `req_o` output 1: memory request.
- `we_o` output 1: memory write enable; constant 0.
- `addr_o` output 32: word address, equal to {2'b00, pc_q[31:2]}.
- `wdata_o` output 32: memory write data; constant 0.
- `rdata_i` input 32: read data; combinational from `addr_o`, valid in the same cycle.
- `instr_valid_o` output 1: FIFO head holds an instruction.
- `instr_o` output 32: instruction at the FIFO head.
- `instr_pc_o` output 32: byte PC of the FIFO head.
- `instr_ready_i` input 1: decode accepts the head instruction.
- `err_o` output 1: misaligned redirect target seen.

## Operation
State machine `state_q`:
- **IDLE**
  - Entered on reset.
  - Moves to FETCH when `fetch_en_i`=1.
- **FETCH**
  - Returns to IDLE when `fetch_en_i`=0.
  - Entries already in the FIFO stay and can still drain.
- **ERR**
  - Entered from any state when a redirect target has `redirect_pc_i[1:0]`≠0.
  - While in ERR: `err_o`=1 and no requests are issued.
  - Left only by an aligned redirect. The next state is FETCH if `fetch_en_i`=1, otherwise IDLE.

Request and push:
- `req_o` = (state==FETCH) & !full & !`redirect_i`.
- When `req_o`=1, the rising edge pushes {`pc_q`, `rdata_i`} into the FIFO and sets `pc_q` ← `pc_q`+4.
- The PC adder wraps modulo 2^32.

Pop:
- `instr_valid_o` = !empty & !`redirect_i`.
- A pop happens when `instr_valid_o` & `instr_ready_i`.
- `instr_o` and `instr_pc_o` are read from registered FIFO storage. No combinational path runs from `rdata_i` to `instr_o`.

Redirect (`redirect_i`=1 at an edge):
- The FIFO is emptied: read pointer, write pointer and count all go to 0.
- Aligned target: `pc_q` ← `redirect_pc_i`.
- Misaligned target: `pc_q` is unchanged and the state goes to ERR.
- A redirect overrides any push or pop in that cycle.

FIFO rules:
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
- Full blocks a request even if a pop happens in the same cycle.
- A simultaneous push and pop when non-empty leaves the count unchanged.

## Timing
- Reset values:
  - `pc_q`=BOOT_ADDR, state IDLE, FIFO empty.
  - `req_o`=0, `instr_valid_o`=0, `instr_o`=0, `instr_pc_o`=0, `err_o`=0.
  - `we_o` and `wdata_o` are always 0.
- Latency:
  - `fetch_en_i` rises at edge N: first `req_o`=1 in cycle N+1.
  - The first `instr_valid_o`=1 follows in cycle N+2.
- Throughput: 1 instruction per cycle sustained when `instr_ready_i`=1 continuously.
- Backpressure: with `instr_ready_i`=0, FETCH issues exactly FIFO_DEPTH requests, then `req_o`=0 until a pop frees an entry. The cycle after the pop, `req_o`=1 again.
- Redirect at edge R: the first fetch from the target happens in cycle R+1 (when in FETCH), and it becomes valid in cycle R+2.
- Reset asserted mid-operation clears all state immediately and asynchronously. The FIFO contents are discarded.

## Configuration
- Macro `IFETCH_PERF_EN`.
- When defined:
  - Adds output `fetch_cnt_o` (32 bits), reset 0.
  - It increments on every pop and wraps at 2^32.
  - Redirects do not clear it.
- When undefined: the port and counter are absent. The remaining behaviour is identical.

## Test plan
- **Reset and start:** reset, then `fetch_en_i`=1 with ready=1 → `addr_o` sequence 1,2,3,…; `instr_pc_o` sequence 4,8,12,…; `instr_o` matches memory words 1,2,3.
- **Backpressure:** ready=0 for 10 cycles → exactly 4 `req_o` pulses, then `req_o`=0. A single pop → one new request next cycle at PC 0x14.
- **Redirect:** FIFO holding 3 entries, `redirect_i`=1 with target 0x40 → next cycle valid=0; then `addr_o`=0x10 and the next valid `instr_pc_o`=0x40.
- **Misaligned redirect:** target 0x42 → `err_o`=1 and `req_o`=0 held. A later redirect to 0x48 → `err_o`=0 and fetch resumes at 0x48.
- **Enable drop:** `fetch_en_i`=0 with 2 entries buffered → no new requests; both entries drain in order with ready=1.
- **Perf counter (`IFETCH_PERF_EN`):** 7 pops then a redirect → `fetch_cnt_o`=7, unchanged by the redirect. Mid-run reset → 0.
